uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter WIDTH, 8, data bits per frame; SHALL match the WIDTH of the upstream FIFO_SYNC.
REQ-002 Parameter CLK_DIV, 16, CLK cycles per serial bit; legal range 2..65535.
REQ-003 Parameter PARITY, 0, 0 = none, 1 = even parity bit after data, 2 = odd parity bit after data.
REQ-004 CLK  input  1  single clock; all logic on posedge CLK.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 EMPTY  input  1  FIFO empty flag; low means RDATA holds a valid head word.
REQ-007 RDATA  input  WIDTH  FIFO head word, first-word fall-through, valid while EMPTY is low.
REQ-008 READ  output  1  pop strobe to FIFO; one pop per cycle in which READ is high.
REQ-009 TXD  output  1  serial line, idle high.
REQ-010 BUSY  output  1  high while a frame is in progress (any state except IDLE).

Function
REQ-011 States SHALL be IDLE, START, DATA, PAR, STOP.
REQ-012 READ SHALL be combinational: high only when EMPTY is low and (state is IDLE, or state is STOP on its last bit cycle), and never during RESET.
REQ-013 On a READ cycle the block SHALL latch RDATA into the shift register and enter START on the next edge.
REQ-014 Each of START, every DATA bit, PAR and STOP SHALL last exactly CLK_DIV cycles, timed by a bit counter that reloads at every bit boundary.
REQ-015 TXD SHALL be registered: 0 in START, the shift register LSB first in DATA, the parity bit in PAR, and 1 in STOP and IDLE.
REQ-016 DATA SHALL emit exactly WIDTH bits, counted by a bit index from 0 to WIDTH-1.
REQ-017 PAR SHALL be entered only when PARITY is nonzero; even parity is the XOR of the data bits, odd parity is its inverse.
REQ-018 A frame SHALL occupy (1 + WIDTH + (PARITY != 0) + 1) x CLK_DIV cycles.
REQ-019 Back-to-back: if EMPTY is low on the last STOP cycle, the next START SHALL begin on the following cycle with no idle gap.
REQ-020 If EMPTY is high on the last STOP cycle, the block SHALL go to IDLE and BUSY SHALL fall on the next edge.
REQ-021 EMPTY and RDATA changes mid-frame SHALL NOT affect the frame in flight.
REQ-022 From IDLE with EMPTY low, TXD SHALL fall one cycle after the READ cycle.

Reset
REQ-023 While RESET is high, on each posedge: state SHALL be IDLE, TXD 1, BUSY 0, counters 0, and the shift register 0.
REQ-024 A RESET asserted mid-frame SHALL abort the frame, drive TXD high from the next edge, and perform no pop for the aborted frame.
REQ-025 The first READ after RESET deasserts SHALL occur no earlier than the first cycle in which RESET is low.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum type (uart_state_t) and the parity-mode constants PAR_NONE, PAR_EVEN and PAR_ODD.
REQ-027 The bit-period counter SHALL be one sub-module, baud_gen (inputs: CLK, RESET, restart; output: tick on the last cycle of each bit period).
REQ-028 The state machine, shift register and bit index SHALL live in uart_tx.

Verification (CLK_DIV=4, WIDTH=8 unless stated)
REQ-029 PARITY=0, push 0x55 -> one READ pulse; TXD over 40 cycles = 0, 1,0,1,0,1,0,1,0, 1 (4 cycles each); BUSY high for exactly 40 cycles.
REQ-030 PARITY=0, push 0x01 and 0x02 together -> exactly two READ pulses 40 cycles apart; 80 contiguous frame cycles; TXD never idle between the frames.
REQ-031 PARITY=1, push 0x07 -> frame of 44 cycles; parity bit = 1. PARITY=2, push 0x07 -> parity bit = 0.
REQ-032 FIFO held empty for 200 cycles -> READ never high, TXD constantly 1, BUSY 0.
REQ-033 Push 0xA5; assert RESET for 1 cycle during DATA bit 3 -> TXD 1 from the next edge, BUSY 0, no further READ until a new word arrives; the next word is sent as a full, correct frame.
REQ-034 Connected to FIFO_SYNC (DEPTH=2) fed with an incrementing counter -> the scoreboard decodes TXD and receives 0x00..0xFE in order with no loss or duplication.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared state type and parity-mode constants for uart_tx
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

`default_nettype wire

// File: rtl/baud_gen.sv
// ============================================================================
// baud_gen : bit-period counter, tick on the last cycle of each bit period
// Rev 1.0
// ============================================================================
`default_nettype none

module baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic restart,
    output logic tick
);

    localparam logic [15:0] c_last = 16'(CLK_DIV - 1);

    logic [15:0] r_cnt;

    // restart pins the count at zero so the first bit of a frame is full length
    always_ff @(posedge CLK) begin
        if (RESET || restart) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx : FIFO-fed UART transmitter, 1 start, WIDTH data, optional parity, 1 stop
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 16,
    parameter int PARITY  = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EMPTY,
    input  logic [WIDTH-1:0] RDATA,
    output logic             READ,
    output logic             TXD,
    output logic             BUSY
);

    localparam int               IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WIDTH - 1);
    localparam logic             c_has_par  = (PARITY != PAR_NONE);
    localparam logic             c_odd      = (PARITY == PAR_ODD);

    uart_state_t      r_state;
    logic [WIDTH-1:0] r_shift;
    logic [IDX_W-1:0] r_idx;
    logic             r_par;
    logic             r_txd;

    logic             w_tick;
    logic             w_restart;
    logic             w_read;
    logic [WIDTH-1:0] w_shift_next;

    assign w_restart    = (r_state == IDLE);
    assign w_shift_next = r_shift >> 1;

    // A pop is only offered where a new frame can start on the next edge
    assign w_read = !RESET && !EMPTY &&
                    ((r_state == IDLE) || ((r_state == STOP) && w_tick));

    baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .CLK     (CLK),
        .RESET   (RESET),
        .restart (w_restart),
        .tick    (w_tick)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    if (w_read) begin
                        r_shift <= RDATA;
                        r_par   <= (^RDATA) ^ c_odd;
                        r_idx   <= '0;
                        r_txd   <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_txd   <= r_shift[0];
                        r_idx   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_idx == c_last_idx) begin
                            r_idx <= '0;
                            if (c_has_par) begin
                                r_txd   <= r_par;
                                r_state <= PAR;
                            end else begin
                                r_txd   <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_shift <= w_shift_next;
                            r_txd   <= w_shift_next[0];
                        end
                    end
                end
                PAR: begin
                    if (w_tick) begin
                        r_txd   <= 1'b1;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        // back-to-back frames reuse the load path of IDLE
                        if (w_read) begin
                            r_shift <= RDATA;
                            r_par   <= (^RDATA) ^ c_odd;
                            r_idx   <= '0;
                            r_txd   <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_txd   <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign READ = w_read;
    assign TXD  = r_txd;
    assign BUSY = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// tb_uart_tx : three transmitters (no/even/odd parity) fed by FIFO models, frames decoded into a scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx;
    import uart_pkg::*;

    localparam int W   = 8;
    localparam int DIV = 4;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic [2:0] read_s;
    logic [2:0] txd_s;
    logic [2:0] busy_s;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] fifo_q [3][$];
    logic [W-1:0] in_q   [3][$];
    logic [W-1:0] exp_q  [3][$];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int FLEN = (2 + W + ((g != 0) ? 1 : 0)) * DIV;

        logic         empty;
        logic [W-1:0] rdata;
        logic         read;
        logic         txd;
        logic         busy;

        uart_tx #(
            .WIDTH   (W),
            .CLK_DIV (DIV),
            .PARITY  (g)
        ) u_dut (
            .CLK   (CLK),
            .RESET (RESET),
            .EMPTY (empty),
            .RDATA (rdata),
            .READ  (read),
            .TXD   (txd),
            .BUSY  (busy)
        );

        assign read_s[g] = read;
        assign txd_s[g]  = txd;
        assign busy_s[g] = busy;

        // First-word fall-through FIFO model; junk on RDATA while empty
        initial begin : fifo_model
            logic r;
            logic rs;
            empty = 1'b1;
            rdata = '0;
            forever begin
                @(negedge CLK);
                #4;
                r  = read;
                rs = RESET;
                @(posedge CLK);
                #1;
                if (r) begin
                    checks++;
                    if (rs || fifo_q[g].size() == 0) begin
                        errors++;
                        $display("FAIL read_legal[%0d] READ=1 with RESET=%0b level=%0d, required READ=0",
                                 g, rs, fifo_q[g].size());
                    end else begin
                        void'(fifo_q[g].pop_front());
                    end
                end
                while (in_q[g].size() > 0) fifo_q[g].push_back(in_q[g].pop_front());
                empty = (fifo_q[g].size() == 0);
                rdata = empty ? W'($urandom) : fifo_q[g][0];
            end
        end

        // Line decoder: captures a whole frame from its falling edge and checks every cycle
        initial begin : monitor
            logic         samp [FLEN];
            logic         aborted;
            int           nbusy;
            int           bad;
            int           b;
            logic         e;
            logic [W-1:0] exp_d;
            logic [W-1:0] got_d;
            forever begin
                @(negedge CLK);
                if (!RESET && txd == 1'b0) begin
                    aborted = 1'b0;
                    nbusy   = 0;
                    for (int k = 0; k < FLEN; k++) begin
                        if (k > 0) @(negedge CLK);
                        if (RESET) begin
                            aborted = 1'b1;
                            break;
                        end
                        samp[k] = txd;
                        if (!busy) nbusy++;
                    end
                    if (!aborted) begin
                        checks++;
                        if (exp_q[g].size() == 0) begin
                            errors++;
                            $display("FAIL frame[%0d] unexpected frame on TXD, required no frame", g);
                        end else begin
                            exp_d = exp_q[g].pop_front();
                            bad   = -1;
                            got_d = '0;
                            for (int k = 0; k < FLEN; k++) begin
                                b = k / DIV;
                                if (b == 0)                 e = 1'b0;
                                else if (b <= W)            e = exp_d[b-1];
                                else if (b == W + 1 && g != 0)
                                    e = (^exp_d) ^ (g == PAR_ODD);
                                else                        e = 1'b1;
                                if (samp[k] !== e && bad < 0) bad = k;
                            end
                            for (int i = 0; i < W; i++) got_d[i] = samp[(i + 1) * DIV + DIV / 2];
                            if (bad >= 0 || nbusy != 0) begin
                                errors++;
                                $display("FAIL frame[%0d] got data 0x%02h first bad cycle %0d busy_low %0d, required data 0x%02h clean",
                                         g, got_d, bad, nbusy, exp_d);
                            end
                        end
                    end
                end
            end
        end
    end

    int rd_cnt [3];
    int busy_cnt [3];
    int max_run [3];
    int txd_low [3];
    int rd_at [3][4];

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic push(input int i, input logic [W-1:0] d);
        in_q[i].push_back(d);
        exp_q[i].push_back(d);
    endtask

    task automatic measure(input int n);
        int run [3];
        for (int i = 0; i < 3; i++) begin
            rd_cnt[i] = 0; busy_cnt[i] = 0; max_run[i] = 0; txd_low[i] = 0; run[i] = 0;
        end
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            for (int i = 0; i < 3; i++) begin
                if (read_s[i]) begin
                    if (rd_cnt[i] < 4) rd_at[i][rd_cnt[i]] = c;
                    rd_cnt[i]++;
                end
                if (!txd_s[i]) txd_low[i]++;
                if (busy_s[i]) begin
                    busy_cnt[i]++;
                    run[i]++;
                    if (run[i] > max_run[i]) max_run[i] = run[i];
                end else begin
                    run[i] = 0;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic producer_count();
        int budget;
        for (int v = 0; v < 255; v++) begin
            budget = 0;
            while (fifo_q[0].size() + in_q[0].size() >= 2 && budget < 200) begin
                @(posedge CLK); #1;
                budget++;
            end
            if (budget >= 200) chk("stream_space_timeout", budget, 0);
            repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
            push(0, W'(v));
        end
    endtask

    task automatic producer_random();
        for (int n = 0; n < 12; n++) begin
            push(1, W'($urandom));
            push(2, W'($urandom));
            repeat ($urandom_range(0, 60)) begin @(posedge CLK); #1; end
        end
    endtask

    initial begin : main
        int budget;
        int seen;

        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_txd",  int'(txd_s),  7);
        chk("reset_busy", int'(busy_s), 0);
        chk("reset_read", int'(read_s), 0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        measure(200);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("idle_read[%0d]", i), rd_cnt[i],   0);
            chk($sformatf("idle_busy[%0d]", i), busy_cnt[i], 0);
            chk($sformatf("idle_txd[%0d]", i),  txd_low[i],  0);
        end

        push(0, 8'h55);
        measure(60);
        chk("x55_reads", rd_cnt[0],   1);
        chk("x55_busy",  busy_cnt[0], 40);

        push(0, 8'h01);
        push(0, 8'h02);
        measure(110);
        chk("b2b_reads",   rd_cnt[0], 2);
        chk("b2b_spacing", rd_at[0][1] - rd_at[0][0], 40);
        chk("b2b_busy",    busy_cnt[0], 80);
        chk("b2b_run",     max_run[0],  80);

        push(1, 8'h07);
        push(2, 8'h07);
        measure(70);
        chk("even_busy",  busy_cnt[1], 44);
        chk("odd_busy",   busy_cnt[2], 44);
        chk("even_reads", rd_cnt[1], 1);
        chk("odd_reads",  rd_cnt[2], 1);

        // 0xA5 is aborted by reset, so it is never expected on the line
        in_q[0].push_back(8'hA5);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (read_s[0]) begin
                seen = 1;
                break;
            end
        end
        chk("abort_read_seen", seen, 1);
        @(posedge CLK); #1;
        repeat (17) begin @(posedge CLK); #1; end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("abort_txd",  int'(txd_s[0]),  1);
        chk("abort_busy", int'(busy_s[0]), 0);
        measure(40);
        chk("abort_no_read", rd_cnt[0],   0);
        chk("abort_idle",    busy_cnt[0] + txd_low[0], 0);
        push(0, 8'h3C);
        measure(60);
        chk("after_abort_reads", rd_cnt[0],   1);
        chk("after_abort_busy",  busy_cnt[0], 40);

        fork
            producer_count();
            producer_random();
        join

        budget = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 ||
                busy_s != 3'b000) && budget < 3000) begin
            @(posedge CLK); #1;
            budget++;
        end
        chk("drain_left", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
        @(negedge CLK);
        chk("final_busy", int'(busy_s), 0);
        chk("final_txd",  int'(txd_s),  7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
